// File: rtl/max_pooling_fprop2_mul_pipe.sv
// Pipelined signed multiplier with rounded arithmetic right shift and wrap/saturate output.
// All stages advance together under ce and downstream back-pressure; bubbles travel with the data.
module max_pooling_fprop2_mul_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 17,
    parameter int din1_WIDTH = 17,
    parameter int dout_WIDTH = 17,
    parameter int SHIFT      = 0,
    parameter int SAT_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  sat
);
    localparam int P = din0_WIDTH + din1_WIDTH;

    // Handshake: the whole pipe moves when enabled and the output slot is free or being taken.
    logic advance;
    assign advance  = ce & (out_ready | ~out_valid);
    assign in_ready = advance;

    // ID only tags the instance; the empty block keeps the parameter referenced.
    if (ID < 0) begin : g_id_tag
    end

    logic signed [P-1:0] a_ext;
    logic signed [P-1:0] b_ext;
    logic signed [P-1:0] mul_p;
    assign a_ext = P'($signed(din0));
    assign b_ext = P'($signed(din1));
    assign mul_p = a_ext * b_ext;

    logic [NUM_STAGE-1:0] vld_q;
    logic signed [P-1:0]  tail_p;
    logic                 tail_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else if (advance) begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    if (NUM_STAGE == 1) begin : g_single
        assign tail_p   = mul_p;
        assign tail_vld = in_valid;
    end else begin : g_multi
        // Product registered in stage 0; later entries are pure delay ahead of the last stage.
        logic signed [P-1:0] p_q [NUM_STAGE-1];
        always_ff @(posedge clk) begin
            if (advance) begin
                p_q[0] <= mul_p;
                for (int i = 1; i < NUM_STAGE - 1; i++) begin
                    p_q[i] <= p_q[i-1];
                end
            end
        end
        assign tail_p   = p_q[NUM_STAGE-2];
        assign tail_vld = vld_q[NUM_STAGE-2];
    end

    logic signed [P:0] r;
    if (SHIFT > 0) begin : g_round
        localparam logic [P:0] HALF = (P+1)'(1) << (SHIFT - 1);
        logic signed [P:0] sum;
        assign sum = {tail_p[P-1], tail_p} + $signed(HALF);
        assign r   = sum >>> SHIFT;
    end else begin : g_noround
        assign r = {tail_p[P-1], tail_p};
    end

    localparam logic signed [P:0] SAT_MAX = {{(P+2-dout_WIDTH){1'b0}}, {(dout_WIDTH-1){1'b1}}};
    localparam logic signed [P:0] SAT_MIN = ~SAT_MAX;

    logic [dout_WIDTH-1:0] nxt_dout;
    logic                  nxt_sat;
    always_comb begin
        nxt_dout = r[dout_WIDTH-1:0];
        nxt_sat  = 1'b0;
        if (SAT_MODE != 0) begin
            if (r > SAT_MAX) begin
                nxt_dout = SAT_MAX[dout_WIDTH-1:0];
                nxt_sat  = 1'b1;
            end else if (r < SAT_MIN) begin
                nxt_dout = SAT_MIN[dout_WIDTH-1:0];
                nxt_sat  = 1'b1;
            end
        end
    end

    // Result registers update only when a real item lands, so they hold across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
            sat  <= 1'b0;
        end else if (advance && tail_vld) begin
            dout <= nxt_dout;
            sat  <= nxt_sat;
        end
    end

    assign out_valid = vld_q[NUM_STAGE-1];

endmodule

// File: tb/tb_max_pooling_fprop2_mul_pipe.sv
// Bench for max_pooling_fprop2_mul_pipe: four configurations share one stimulus stream,
// each checked every cycle against a queue-based arithmetic model.
module tb_max_pooling_fprop2_mul_pipe;
    localparam int NCFG = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [16:0] din0 = '0;
    logic [16:0] din1 = '0;
    logic        chk_en = 1'b0;

    logic        in_ready_w  [NCFG];
    logic        out_valid_w [NCFG];
    logic        sat_w       [NCFG];
    logic [16:0] dout_w      [NCFG];

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int cfg, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cfg%0d @%0t: got %0h, want %0h", name, cfg, $time, got, want);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int NS = (g == 1) ? 1 : (g == 2) ? 4 : 2;
        localparam int SH = (g >= 2) ? 4 : 0;
        localparam int SM = (g == 1 || g == 2) ? 1 : 0;

        max_pooling_fprop2_mul_pipe #(
            .ID(g + 1), .NUM_STAGE(NS), .din0_WIDTH(17), .din1_WIDTH(17),
            .dout_WIDTH(17), .SHIFT(SH), .SAT_MODE(SM)
        ) dut (
            .clk(clk), .reset(reset), .ce(ce),
            .in_valid(in_valid), .in_ready(in_ready_w[g]),
            .din0(din0), .din1(din1),
            .out_valid(out_valid_w[g]), .out_ready(out_ready),
            .dout(dout_w[g]), .sat(sat_w[g])
        );

        // Expected {sat, dout} from plain integer arithmetic.
        function automatic logic [17:0] model(input longint a, input longint b);
            longint p, r, half;
            p    = a * b;
            half = (longint'(1) <<< SH) / 2;
            r    = (p + half) >>> SH;
            if (SM != 0 && r > 65535)  return {1'b1, 17'h0FFFF};
            if (SM != 0 && r < -65536) return {1'b1, 17'h10000};
            return {1'b0, r[16:0]};
        endfunction

        logic [17:0]   exp_q[$];
        logic [NS-1:0] mvld     = '0;
        logic [17:0]   last_out = '0;

        always @(negedge clk) begin
            logic ov;
            ov = mvld[NS-1];
            if (chk_en) begin
                check("out_valid", g, 32'(out_valid_w[g]), 32'(ov));
                check("in_ready", g, 32'(in_ready_w[g]), 32'(ce & (out_ready | ~ov)));
                if (ov)
                    check("result", g, 32'({sat_w[g], dout_w[g]}), 32'(exp_q[0]));
                else
                    check("held_result", g, 32'({sat_w[g], dout_w[g]}), 32'(last_out));
            end
            if (reset) begin
                exp_q.delete();
                mvld     = '0;
                last_out = '0;
            end else if (ce && (out_ready || !ov)) begin
                if (ov) last_out = exp_q.pop_front();
                for (int i = NS - 1; i > 0; i--) mvld[i] = mvld[i-1];
                mvld[0] = in_valid;
                if (in_valid) exp_q.push_back(model(longint'($signed(din0)), longint'($signed(din1))));
            end
        end
    end

    function automatic logic [16:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 17'h10000;
            1:       return 17'h0FFFF;
            2:       return 17'h00000;
            3:       return 17'h1FFFF;
            default: return 17'($urandom);
        endcase
    endfunction

    task automatic step(input logic v, input logic r, input logic c, input logic rst,
                        input logic [16:0] a, input logic [16:0] b);
        @(posedge clk);
        #1;
        in_valid  = v;
        out_ready = r;
        ce        = c;
        reset     = rst;
        din0      = a;
        din1      = b;
    endtask

    initial begin
        // Model pins: hand-computed results for each configuration.
        check("pin_neg", 0, 32'(g_cfg[0].model(-3, 5)), 32'h1FFF1);
        check("pin_wrap", 0, 32'(g_cfg[0].model(65535, 65535)), 32'h00001);
        check("pin_satpos", 1, 32'(g_cfg[1].model(65535, 65535)), 32'h2FFFF);
        check("pin_satmin2", 1, 32'(g_cfg[1].model(-65536, -65536)), 32'h2FFFF);
        check("pin_rnd_pos", 2, 32'(g_cfg[2].model(7, 3)), 32'h00001);
        check("pin_rnd_neg", 2, 32'(g_cfg[2].model(-7, 3)), 32'h1FFFF);
        check("pin_rnd_half", 3, 32'(g_cfg[3].model(8, 1)), 32'h00001);
        check("pin_satneg", 2, 32'(g_cfg[2].model(-65536, 65535)), 32'h30000);

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        reset  = 1'b0;

        // Single operand: latency per configuration.
        step(1, 1, 1, 0, 17'h1FFFD, 17'd5);
        step(0, 1, 1, 0, 17'h0, 17'h0);
        @(negedge clk);
        check("lat1_valid", 1, 32'(out_valid_w[1]), 32'h1);
        check("lat1_dout", 1, 32'({sat_w[1], dout_w[1]}), 32'h1FFF1);
        check("lat2_early", 0, 32'(out_valid_w[0]), 32'h0);
        @(negedge clk);
        check("lat2_valid", 0, 32'(out_valid_w[0]), 32'h1);
        check("lat2_dout", 0, 32'({sat_w[0], dout_w[0]}), 32'h1FFF1);
        check("lat2_rnd", 3, 32'({sat_w[3], dout_w[3]}), 32'h1FFFF);
        check("lat4_early", 2, 32'(out_valid_w[2]), 32'h0);
        repeat (2) @(negedge clk);
        check("lat4_valid", 2, 32'(out_valid_w[2]), 32'h1);
        check("lat4_dout", 2, 32'({sat_w[2], dout_w[2]}), 32'h1FFFF);

        // Boundary operands back-to-back.
        step(1, 1, 1, 0, 17'h0FFFF, 17'h0FFFF);
        step(1, 1, 1, 0, 17'h10000, 17'h10000);
        step(1, 1, 1, 0, 17'd7, 17'd3);
        step(1, 1, 1, 0, 17'h1FFF9, 17'd3);
        step(1, 1, 1, 0, 17'd8, 17'd1);
        step(1, 1, 1, 0, 17'h10000, 17'h0FFFF);
        repeat (6) step(0, 1, 1, 0, 17'h0, 17'h0);

        // Stream with a 3-cycle out_ready drop mid-stream.
        for (int i = 0; i < 10; i++)
            step(i < 6, !(i >= 3 && i < 6), 1, 0, rand_op(), rand_op());
        repeat (6) step(0, 1, 1, 0, 17'h0, 17'h0);

        // Fill the pipe, freeze with ce=0 for 4 cycles, then resume.
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, rand_op(), rand_op());
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, rand_op(), rand_op());
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, rand_op(), rand_op());
        repeat (6) step(0, 1, 1, 0, 17'h0, 17'h0);

        // Reset with items in flight; operand offered during reset is discarded.
        step(1, 1, 1, 0, rand_op(), rand_op());
        step(1, 1, 1, 0, rand_op(), rand_op());
        step(1, 1, 1, 1, rand_op(), rand_op());
        repeat (6) step(0, 1, 1, 0, 17'h0, 17'h0);

        // Randomized traffic with occasional stalls, freezes and resets.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 199) == 0, rand_op(), rand_op());

        repeat (10) step(0, 1, 1, 0, 17'h0, 17'h0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
